// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit: issues sequential fetches, tags in-order responses
// with their PC, and buffers them in a small circular queue ahead of decode.
module if_prefetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    input  logic            out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]     DEPTH_L = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] resp_pc_reg;
    logic [CW-1:0]   inflight_reg;
    logic [CW-1:0]   stale_reg;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic            grant;
    logic            resp;
    logic            push;
    logic            pop;
    logic [CW:0]     occupancy;
    logic [CW-1:0]   inflight_after_resp;

    // Every outstanding request owns a queue slot, so the queue can never overflow.
    assign occupancy           = {1'b0, inflight_reg} + {1'b0, count_reg};
    assign imem_req            = !reset && !redirect_valid && (occupancy < DEPTH_L);
    assign imem_addr           = fetch_pc_reg;
    assign grant               = imem_req && imem_gnt;
    assign resp                = imem_rvalid && (inflight_reg != '0);
    assign push                = resp && (stale_reg == '0) && !redirect_valid;
    assign out_valid           = (count_reg != '0);
    assign pop                 = out_valid && out_ready && !redirect_valid;
    assign inflight_after_resp = inflight_reg - CW'(resp);
    assign out_pc              = out_valid ? pc_mem[rd_ptr_reg] : '0;
    assign out_instr           = out_valid ? instr_mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            inflight_reg <= '0;
            stale_reg    <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc_reg <= redirect_pc;
            resp_pc_reg  <= redirect_pc;
            inflight_reg <= inflight_after_resp;
            stale_reg    <= inflight_after_resp;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            if (grant) begin
                fetch_pc_reg <= fetch_pc_reg + STEP;
            end
            inflight_reg <= inflight_after_resp + CW'(grant);
            if (resp && (stale_reg != '0)) begin
                stale_reg <= stale_reg - CW'(1);
            end
            if (push) begin
                wr_ptr_reg  <= wr_ptr_reg + AW'(1);
                resp_pc_reg <= resp_pc_reg + STEP;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= resp_pc_reg;
            instr_mem[wr_ptr_reg] <= imem_rdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_reg == FULL)));

    // A response with nothing outstanding is dropped by the resp gating above.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (inflight_reg == '0)));

endmodule

// File: doc/if_prefetch_unit.md
IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address/PC width, 32 or 64.
REQ-002 Parameter DEPTH, default 4: prefetch queue entries, power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; port order and set:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous, active-high reset
  redirect_valid  in  1  branch/jump redirect strobe
  redirect_pc  in  XLEN  redirect target
  imem_req  out  1  fetch request
  imem_addr  out  XLEN  fetch address
  imem_gnt  in  1  request accepted this cycle
  imem_rvalid  in  1  in-order response valid
  imem_rdata  in  32  response instruction word
  out_valid  out  1  queue head valid to decode
  out_pc  out  XLEN  PC of queue head
  out_instr  out  32  instruction of queue head
  out_ready  in  1  decode accepts head (low = stall)

Function
REQ-005 State: fetch_pc, resp_pc (XLEN); inflight, stale, count ($clog2(DEPTH)+1 bits); DEPTH-entry circular queue of {pc, instr} with rd/wr pointers.
REQ-006 imem_req SHALL be 1 iff redirect_valid=0 and inflight+count < DEPTH; imem_addr = fetch_pc.
REQ-007 Grant (imem_req & imem_gnt): fetch_pc += 4 modulo 2^XLEN; inflight += 1.
REQ-008 Once asserted, imem_req and imem_addr SHALL hold stable until granted, except on a redirect cycle.
REQ-009 Response (imem_rvalid): inflight -= 1; if stale != 0 then stale -= 1 and word discarded; else push {resp_pc, imem_rdata}, resp_pc += 4 modulo 2^XLEN.
REQ-010 Pop when out_valid & out_ready; out_valid = (count != 0); out_pc/out_instr driven combinationally from the head entry.
REQ-011 Latency: response accepted at cycle N -> out_valid at N+1 (no bypass); grant-to-response latency set by memory, >= 1 cycle.
REQ-012 Simultaneous push and pop in one cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-013 Queue SHALL never overflow: REQ-006 reserves a slot per in-flight request; push when full is unreachable; an assertion SHALL flag it.
REQ-014 Redirect (redirect_valid=1) has priority: queue emptied (count=0, pointers reset), fetch_pc <= redirect_pc, resp_pc <= redirect_pc, stale <= inflight after this cycle's response, no grant possible that cycle.
REQ-015 A same-cycle pop or response during a redirect SHALL be discarded; out_valid=0 the next cycle.
REQ-016 Back-to-back redirects: the latest target wins; stale accumulates all outstanding requests.
REQ-017 Response with inflight=0 is a protocol error; SHALL be ignored and flagged by an assertion.

Reset
REQ-018 Reset assertion SHALL immediately force imem_req=0, out_valid=0, independent of clk.
REQ-019 During reset: fetch_pc=resp_pc=RESET_PC, inflight=stale=count=0, pointers=0; out_pc=0, out_instr=0.
REQ-020 First request SHALL issue in the first cycle after reset deasserts, imem_addr=RESET_PC.
REQ-021 Reset mid-operation SHALL drop all in-flight requests; memory shall be reset with the block.

Verification
REQ-022 Streaming: gnt=1, 1-cycle response, out_ready=1 -> out_pc 0x0,0x4,0x8,... consecutive cycles, instr matches memory.
REQ-023 Stall fill: out_ready=0, DEPTH=4 -> exactly 4 grants, imem_req low after, count=4; out_ready=1 -> 4 in-order pops, fetching resumes.
REQ-024 Redirect with 2 in flight: redirect_pc=0x100 -> next 2 responses dropped, first out_pc=0x100, no stale word reaches out.
REQ-025 Redirect coincident with rvalid and pop -> both discarded, out_valid=0 next cycle, stale=inflight-1.
REQ-026 Wrap: XLEN=32, redirect_pc=0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000.
REQ-027 Async reset asserted between clock edges with queue full -> imem_req=0, out_valid=0 before next edge; restart at RESET_PC.
